// File: rtl/imm_ext_if.sv
// imm_ext_if -- request/result bundle for imm_ext_pipe.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The sender keeps valid and its
// payload stable until that edge; ready may change freely and never
// depends combinationally on the sender's payload.
//
// Signals
//   in_valid, ext_sel[2:0], instr[31:0], pc[DW-1:0]  request from master
//   in_ready                                           request acceptance
//   out_valid, out_data[DW-1:0], out_err               result to master
//   out_ready                                          result consumption
//
// Modports: master = requester/consumer side, slave = imm_ext_pipe side.
interface imm_ext_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    ext_sel;
  logic [31:0]   instr;
  logic [DW-1:0] pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  modport master (
    output in_valid, ext_sel, instr, pc, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, ext_sel, instr, pc, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe -- immediate / branch-target extension unit with an in-order
// result FIFO.
//
// Each accepted request is decoded by ext_sel into a DW-bit result that is
// pushed into a DEPTH-entry FIFO; the head entry is presented on the result
// channel one cycle after acceptance when the FIFO was empty.
//
// Ports
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset (dominates flush)
//   flush  synchronous squash of every buffered result
//   bus    imm_ext_if.slave (request and result channels)
//
// Parameters
//   DW     datapath width, 32 or 64
//   DEPTH  FIFO entries, power of two, >= 2
//
// Build option
//   IMM_EXT_PIPE_ERR_EN  when defined, each entry carries an illegal-mode
//                        bit (ext_sel == 7) shown on out_err; otherwise
//                        out_err is tied low.
module imm_ext_pipe #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  imm_ext_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] sext16;
  logic [DW-1:0] result;
  logic          is_illegal;
  logic          full;
  logic          push;
  logic          pop;
  logic          unused_bits;

  // Result decode. Mode 3 ({imm16,16'b0} sign-extended from bit 31) is the
  // same bit pattern as the sign-extended imm16 shifted left by 16, which
  // keeps it free of a zero-width replication when DW == 32.
  always_comb begin
    sext16     = {{(DW-16){bus.instr[15]}}, bus.instr[15:0]};
    result     = '0;
    is_illegal = 1'b0;
    case (bus.ext_sel)
      3'd0: result = {{(DW-16){1'b0}}, bus.instr[15:0]};
      3'd1: result = sext16;
      3'd2: result = {{(DW-5){1'b0}}, bus.instr[10:6]};
      3'd3: result = sext16 << 16;
      3'd4: result = sext16 << 2;
      3'd5: result = {bus.pc[DW-1:28], bus.instr[25:0], 2'b00};
      3'd6: result = bus.pc + DW'(4) + (sext16 << 2);
      default: begin
        result     = '0;
        is_illegal = 1'b1;
      end
    endcase
  end

  // Opcode field bits are not part of any extension mode.
  assign unused_bits = ^{bus.instr[31:26], is_illegal};

  assign full = (count == CW'(DEPTH));

  // A full FIFO still accepts when the head leaves on the same edge.
  assign bus.in_ready  = rst_n && !flush && (!full || bus.out_ready);
  assign bus.out_valid = rst_n && (count != '0);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

  assign bus.out_data = bus.out_valid ? mem[rd_ptr] : '0;

`ifdef IMM_EXT_PIPE_ERR_EN
  logic err_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) err_mem[wr_ptr] <= is_illegal;
  end

  assign bus.out_err = bus.out_valid && err_mem[rd_ptr];
`else
  assign bus.out_err = 1'b0;
`endif
endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter DW, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 2, result buffer entries; power of two, >=2.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous squash of all buffered results.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  request accepted when in_valid&&in_ready at clk edge.
REQ-008 ext_sel  input  3  extension mode (REQ-013).
REQ-009 instr  input  32  instruction word; imm16=instr[15:0], shamt=instr[10:6], imm26=instr[25:0].
REQ-010 pc  input  DW  address of the instruction.
REQ-011 out_valid / out_ready  output / input  1 each  result handshake, transfer when both high.
REQ-012 out_data  output  DW  result; out_err  output  1  illegal-mode flag (REQ-024 only).

Function
REQ-013 ext_sel decode: 0 zero-ext imm16; 1 sign-ext imm16; 2 zero-ext shamt; 3 {imm16,16'b0} sign-extended from bit 31 to DW; 4 sign-ext(imm16)<<2; 5 {pc[DW-1:28],imm26,2'b00}; 6 pc+4+(sign-ext(imm16)<<2); 7 illegal, result 0.
REQ-014 All arithmetic modulo 2^DW; mode 6 wraps silently with no carry-out.
REQ-015 Result computed from inputs sampled at acceptance, written into an in-order FIFO of DEPTH entries.
REQ-016 Latency exactly 1 cycle: request accepted at edge N is visible on out_valid/out_data after edge N when the FIFO was empty; no combinational input-to-output path.
REQ-017 out_valid=1 iff FIFO non-empty; out_data/out_err show head entry, held stable while out_valid&&!out_ready.
REQ-018 in_ready=1 iff FIFO count<DEPTH, or count==DEPTH and out_ready=1 (simultaneous pop frees a slot); in_ready=0 while flush=1.
REQ-019 Simultaneous push and pop: count unchanged, order preserved; full throughput of one result per cycle sustained.
REQ-020 Pointers wrap modulo DEPTH; count range 0..DEPTH, never overflows or underflows.
REQ-021 Pop when empty and push when full (in_ready=0) are ignored, no state change.
REQ-022 flush=1 at an edge: count<=0, pointers<=0, out_valid=0 next cycle; concurrent push and pop discarded; flush dominates all.

Reset
REQ-023 rst_n=0 at an edge: count, pointers <=0; out_valid=0, out_data=0, out_err=0, in_ready=0 while rst_n=0; in_ready=1 first cycle after release; reset mid-transfer discards all entries, has priority over flush.

Configuration
REQ-024 Macro IMM_EXT_PIPE_ERR_EN: defined -> each FIFO entry stores an error bit set for ext_sel=7, presented on out_err alongside the entry; undefined -> no error storage, out_err tied 0, ext_sel=7 still yields 0.

Verification
REQ-025 DW=32, sel=1, instr[15:0]=16'h8000, out_ready=1 -> out_data=32'hFFFF8000 one cycle after acceptance.
REQ-026 DW=64, sel=3, imm16=16'h8001 -> 64'hFFFFFFFF80010000; sel=6, pc=64'h0000_0000_0040_0000, imm16=16'hFFFF -> 64'h0000_0000_0040_0000.
REQ-027 sel=5, pc=32'hA000_0000, imm26=26'h3FFFFFF -> 32'hAFFFFFFC; sel=2, instr[10:6]=5'd31 -> 32'd31.
REQ-028 DEPTH=2, out_ready=0, push 3 back-to-back -> in_ready=0 after 2nd accept; out_ready=1 for one cycle with in_valid=1 -> 3rd accepted same edge, outputs in order 1,2,3.
REQ-029 FIFO holding 2 entries, flush=1 with in_valid=1 -> next cycle out_valid=0, third request not accepted; rst_n=0 mid-stream -> out_valid=0, out_data=0.
REQ-030 ERR_EN defined, sel=7 -> out_data=0, out_err=1; undefined -> out_data=0, out_err=0.
